// File: rtl/daw_pkg.sv
// Shared types and constants for the sample playback path.
package daw_pkg;

  localparam int unsigned SAMPLE_W = 16;

  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ADVANCE = 2'd1,
    SETTLE  = 2'd2
  } reader_state_t;

  localparam sample_t SILENCE = '0;

endpackage

// File: rtl/fifo_level_tracker.sv
// Saturating occupancy counter for the sample FIFO, with sticky overflow flag.
module fifo_level_tracker #(
  parameter  int unsigned DEPTH = 512,
  localparam int unsigned LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  input  logic             clear,
  output logic [LVL_W-1:0] level,
  output logic             overflow
);

  logic [LVL_W-1:0] level_q, level_d;
  logic             overflow_q, overflow_d;

  // Next occupancy; a write into a full FIFO saturates and flags overflow (set beats clear).
  always_comb begin
    level_d    = level_q;
    overflow_d = overflow_q;
    if (clear) begin
      overflow_d = 1'b0;
    end
    if (inc && !dec) begin
      if (level_q == LVL_W'(DEPTH)) begin
        overflow_d = 1'b1;
      end else begin
        level_d = level_q + LVL_W'(1);
      end
    end else if (dec && !inc) begin
      level_d = level_q - LVL_W'(1);
    end
  end

  // Occupancy and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  assign level    = level_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/fifo_playback_reader.sv
// Consumer end of the sample FIFO: one sample per audio tick, silence on underrun.
module fifo_playback_reader
  import daw_pkg::*;
#(
  parameter  int unsigned WIDTH      = 16,
  parameter  int unsigned DEPTH      = 512,
  parameter  int unsigned RD_LATENCY = 2,
  localparam int unsigned LVL_W      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample_tick,
  input  logic             wr_event,
  output logic             fifo_rd,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic [WIDTH-1:0] sample_out,
  output logic             sample_valid,
  output logic [LVL_W-1:0] level,
  output logic             underrun,
  output logic             overflow,
  output logic             tick_missed,
  input  logic             clear_flags
);

  localparam int unsigned CNT_W = $clog2(RD_LATENCY + 2);

  reader_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pending_q, pending_d;
  logic             fifo_rd_q, fifo_rd_d;
  logic [WIDTH-1:0] sample_q, sample_d;
  logic             valid_q, valid_d;
  logic             underrun_q, underrun_d;
  logic             missed_q, missed_d;
  logic             dec_c;
  logic             can_serve_c;
  logic             serve_c;

  // The FIFO head is consumed in the ADVANCE cycle.
  assign dec_c = (state_q == ADVANCE);

  fifo_level_tracker #(
    .DEPTH (DEPTH)
  ) u_level (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (wr_event),
    .dec      (dec_c),
    .clear    (clear_flags),
    .level    (level),
    .overflow (overflow)
  );

  // A tick is served only in IDLE and never right after a valid pulse, so valid cannot repeat back-to-back.
  assign can_serve_c = (state_q == IDLE) && !valid_q;
  assign serve_c     = can_serve_c && (sample_tick || pending_q);

  // Next-state, tick bookkeeping and sample capture.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pending_d  = pending_q;
    fifo_rd_d  = 1'b0;
    sample_d   = sample_q;
    valid_d    = 1'b0;
    underrun_d = underrun_q & ~clear_flags;
    missed_d   = missed_q & ~clear_flags;

    if (can_serve_c) begin
      pending_d = 1'b0;
      if (pending_q && sample_tick) begin
        missed_d = 1'b1;
      end
    end else if (sample_tick) begin
      if (pending_q) begin
        missed_d = 1'b1;
      end else begin
        pending_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (serve_c) begin
          valid_d = 1'b1;
          if (level != '0) begin
            sample_d  = fifo_dout;
            fifo_rd_d = 1'b1;
            state_d   = ADVANCE;
          end else begin
            sample_d   = WIDTH'(SILENCE);
            underrun_d = 1'b1;
          end
        end
      end
      ADVANCE: begin
        cnt_d   = CNT_W'(RD_LATENCY + 1);
        state_d = SETTLE;
      end
      SETTLE: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pending_q  <= 1'b0;
      fifo_rd_q  <= 1'b0;
      sample_q   <= '0;
      valid_q    <= 1'b0;
      underrun_q <= 1'b0;
      missed_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pending_q  <= pending_d;
      fifo_rd_q  <= fifo_rd_d;
      sample_q   <= sample_d;
      valid_q    <= valid_d;
      underrun_q <= underrun_d;
      missed_q   <= missed_d;
    end
  end

  assign fifo_rd      = fifo_rd_q;
  assign sample_out   = sample_q;
  assign sample_valid = valid_q;
  assign underrun     = underrun_q;
  assign tick_missed  = missed_q;

endmodule

// File: tb/tb_fifo_playback_reader.sv
// Bench for fifo_playback_reader: a behavioural FIFO with 2-cycle read latency plus a transaction-level model.
module tb_fifo_playback_reader;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 512;
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             sample_tick = 1'b0;
  logic             wr_event = 1'b0;
  logic             fifo_rd;
  logic [WIDTH-1:0] fifo_dout;
  logic [WIDTH-1:0] sample_out;
  logic             sample_valid;
  logic [LVL_W-1:0] level;
  logic             underrun;
  logic             overflow;
  logic             tick_missed;
  logic             clear_flags = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  fifo_playback_reader #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .RD_LATENCY (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_tick  (sample_tick),
    .wr_event     (wr_event),
    .fifo_rd      (fifo_rd),
    .fifo_dout    (fifo_dout),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .level        (level),
    .underrun     (underrun),
    .overflow     (overflow),
    .tick_missed  (tick_missed),
    .clear_flags  (clear_flags)
  );

  always #5 clk = ~clk;

  // Behavioural FIFO: read pointer moves on fifo_rd, head data appears two cycles after the move.
  logic [WIDTH-1:0] mem [0:1023];
  int unsigned      wr_ptr = 0;
  logic [9:0]       rd_ptr, p1, p2;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      p1     <= '0;
      p2     <= '0;
    end else begin
      if (fifo_rd) rd_ptr <= rd_ptr + 10'd1;
      p1 <= rd_ptr;
      p2 <= p1;
    end
  end

  assign fifo_dout = mem[p2];

  // Cumulative monitors: read strobes issued and back-to-back valid pulses.
  int   rd_pulses = 0;
  int   dbl_valid = 0;
  logic prev_valid = 1'b0;

  always @(posedge clk) begin
    prev_valid <= sample_valid;
    if (sample_valid && prev_valid) dbl_valid = dbl_valid + 1;
    if (fifo_rd) rd_pulses = rd_pulses + 1;
  end

  task automatic do_reset();
    rst_n       = 1'b0;
    sample_tick = 1'b0;
    wr_event    = 1'b0;
    clear_flags = 1'b0;
    wr_ptr      = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic push(input logic [WIDTH-1:0] data);
    mem[wr_ptr % 1024] = data;
    wr_ptr   = wr_ptr + 1;
    wr_event = 1'b1;
    @(negedge clk);
    wr_event = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks = n_checks + 7;
    if (fifo_rd !== 1'b0)      begin n_fail++; $display("FAIL reset_fifo_rd: got %b expected 0", fifo_rd); end
    if (sample_out !== '0)     begin n_fail++; $display("FAIL reset_sample_out: got %h expected 0000", sample_out); end
    if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", sample_valid); end
    if (level !== '0)          begin n_fail++; $display("FAIL reset_level: got %0d expected 0", level); end
    if (underrun !== 1'b0)     begin n_fail++; $display("FAIL reset_underrun: got %b expected 0", underrun); end
    if (overflow !== 1'b0)     begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    if (tick_missed !== 1'b0)  begin n_fail++; $display("FAIL reset_tick_missed: got %b expected 0", tick_missed); end
  endtask

  task automatic test_playback();
    logic [WIDTH-1:0] vals [3];
    vals[0] = 16'h1111; vals[1] = 16'h2222; vals[2] = 16'h3333;
    for (int i = 0; i < 3; i++) push(vals[i]);
    n_checks++;
    if (level !== LVL_W'(3)) begin n_fail++; $display("FAIL play_level_init: got %0d expected 3", level); end
    for (int i = 0; i < 3; i++) begin
      repeat (95) @(negedge clk);
      sample_tick = 1'b1;
      n_checks++;
      if (fifo_rd !== 1'b0) begin n_fail++; $display("FAIL play_rd_at_t[%0d]: got %b expected 0", i, fifo_rd); end
      @(negedge clk);
      sample_tick = 1'b0;
      n_checks = n_checks + 3;
      if (sample_valid !== 1'b1) begin n_fail++; $display("FAIL play_valid[%0d]: got %b expected 1", i, sample_valid); end
      if (sample_out !== vals[i]) begin n_fail++; $display("FAIL play_sample[%0d]: got %h expected %h", i, sample_out, vals[i]); end
      if (fifo_rd !== 1'b1) begin n_fail++; $display("FAIL play_rd_at_t1[%0d]: got %b expected 1", i, fifo_rd); end
      @(negedge clk);
      n_checks = n_checks + 2;
      if (fifo_rd !== 1'b0) begin n_fail++; $display("FAIL play_rd_at_t2[%0d]: got %b expected 0", i, fifo_rd); end
      if (level !== LVL_W'(2 - i)) begin n_fail++; $display("FAIL play_level[%0d]: got %0d expected %0d", i, level, 2 - i); end
    end
  endtask

  task automatic test_underrun();
    int rd0;
    repeat (10) @(negedge clk);
    rd0 = rd_pulses;
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    n_checks = n_checks + 3;
    if (sample_out !== '0)     begin n_fail++; $display("FAIL under_sample: got %h expected 0000", sample_out); end
    if (sample_valid !== 1'b1) begin n_fail++; $display("FAIL under_valid: got %b expected 1", sample_valid); end
    if (underrun !== 1'b1)     begin n_fail++; $display("FAIL under_flag: got %b expected 1", underrun); end
    repeat (8) @(negedge clk);
    n_checks++;
    if (rd_pulses !== rd0) begin n_fail++; $display("FAIL under_no_rd: got %0d strobes expected 0", rd_pulses - rd0); end
    clear_flags = 1'b1;
    @(negedge clk);
    clear_flags = 1'b0;
    n_checks++;
    if (underrun !== 1'b0) begin n_fail++; $display("FAIL under_clear: got %b expected 0", underrun); end
    repeat (4) @(negedge clk);
    sample_tick = 1'b1;
    clear_flags = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    clear_flags = 1'b0;
    n_checks++;
    if (underrun !== 1'b1) begin n_fail++; $display("FAIL under_set_wins: got %b expected 1", underrun); end
    clear_flags = 1'b1;
    @(negedge clk);
    clear_flags = 1'b0;
  endtask

  task automatic test_pending();
    logic exp_rd;
    push(16'hA001); push(16'hA002); push(16'hA003); push(16'hA004);
    repeat (6) @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    n_checks = n_checks + 2;
    if (fifo_rd !== 1'b1) begin n_fail++; $display("FAIL pend_rd_t1: got %b expected 1", fifo_rd); end
    if (sample_out !== 16'hA001) begin n_fail++; $display("FAIL pend_first: got %h expected a001", sample_out); end
    @(negedge clk);
    for (int k = 2; k <= 6; k++) begin
      sample_tick = (k == 2);
      exp_rd = (k == 6);
      n_checks = n_checks + 2;
      if (fifo_rd !== exp_rd) begin n_fail++; $display("FAIL pend_rd_t%0d: got %b expected %b", k, fifo_rd, exp_rd); end
      if (sample_valid !== exp_rd) begin n_fail++; $display("FAIL pend_valid_t%0d: got %b expected %b", k, sample_valid, exp_rd); end
      if (k == 6) begin
        n_checks++;
        if (sample_out !== 16'hA002) begin n_fail++; $display("FAIL pend_second: got %h expected a002", sample_out); end
      end
      @(negedge clk);
      sample_tick = 1'b0;
    end
    n_checks++;
    if (tick_missed !== 1'b0) begin n_fail++; $display("FAIL pend_no_miss: got %b expected 0", tick_missed); end
    repeat (10) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      sample_tick = 1'b1;
      @(negedge clk);
    end
    sample_tick = 1'b0;
    repeat (12) @(negedge clk);
    n_checks = n_checks + 3;
    if (tick_missed !== 1'b1) begin n_fail++; $display("FAIL miss_flag: got %b expected 1", tick_missed); end
    if (level !== '0) begin n_fail++; $display("FAIL miss_level: got %0d expected 0", level); end
    if (sample_out !== 16'hA004) begin n_fail++; $display("FAIL miss_sample: got %h expected a004", sample_out); end
    clear_flags = 1'b1;
    @(negedge clk);
    clear_flags = 1'b0;
    n_checks++;
    if (tick_missed !== 1'b0) begin n_fail++; $display("FAIL miss_clear: got %b expected 0", tick_missed); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < int'(DEPTH); i++) push(WIDTH'(i));
    n_checks = n_checks + 2;
    if (level !== LVL_W'(DEPTH)) begin n_fail++; $display("FAIL ovf_full_level: got %0d expected %0d", level, DEPTH); end
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %b expected 0", overflow); end
    push(16'hFFFF);
    n_checks = n_checks + 2;
    if (level !== LVL_W'(DEPTH)) begin n_fail++; $display("FAIL ovf_sat_level: got %0d expected %0d", level, DEPTH); end
    if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", overflow); end

    do_reset();
    for (int i = 0; i < 5; i++) push(16'h0500 + WIDTH'(i));
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    n_checks++;
    if (fifo_rd !== 1'b1) begin n_fail++; $display("FAIL same_cycle_rd: got %b expected 1", fifo_rd); end
    mem[wr_ptr % 1024] = 16'h0505;
    wr_ptr   = wr_ptr + 1;
    wr_event = 1'b1;
    @(negedge clk);
    wr_event = 1'b0;
    n_checks = n_checks + 2;
    if (level !== LVL_W'(5)) begin n_fail++; $display("FAIL same_cycle_level: got %0d expected 5", level); end
    if (overflow !== 1'b0) begin n_fail++; $display("FAIL same_cycle_ovf: got %b expected 0", overflow); end
  endtask

  task automatic test_reset_mid();
    int rd0;
    do_reset();
    push(16'hBEEF);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    n_checks++;
    if (fifo_rd !== 1'b1) begin n_fail++; $display("FAIL mid_rd_before: got %b expected 1", fifo_rd); end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (fifo_rd !== 1'b0) begin n_fail++; $display("FAIL mid_rd_async: got %b expected 0", fifo_rd); end
    wr_ptr = 0;
    @(negedge clk);
    rst_n = 1'b1;
    rd0 = rd_pulses;
    @(negedge clk);
    n_checks = n_checks + 2;
    if (level !== '0) begin n_fail++; $display("FAIL mid_level: got %0d expected 0", level); end
    if (sample_out !== '0) begin n_fail++; $display("FAIL mid_sample: got %h expected 0000", sample_out); end
    repeat (6) @(negedge clk);
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    n_checks = n_checks + 3;
    if (sample_valid !== 1'b1) begin n_fail++; $display("FAIL mid_silence_valid: got %b expected 1", sample_valid); end
    if (sample_out !== '0) begin n_fail++; $display("FAIL mid_silence: got %h expected 0000", sample_out); end
    if (underrun !== 1'b1) begin n_fail++; $display("FAIL mid_underrun: got %b expected 1", underrun); end
    repeat (6) @(negedge clk);
    n_checks++;
    if (rd_pulses !== rd0) begin n_fail++; $display("FAIL mid_no_rd: got %0d strobes expected 0", rd_pulses - rd0); end
  endtask

  // Random ticks and writes against a model that only tracks queue occupancy and contents.
  task automatic test_random();
    int               mdl_level;
    int               pops;
    int               since;
    int               rd0;
    logic             exp_ur;
    logic             tick, wr, prev_wr, prev_tick;
    logic [WIDTH-1:0] exp_sample;
    do_reset();
    mdl_level = 0; pops = 0; since = 100; exp_ur = 1'b0;
    prev_wr = 1'b0; prev_tick = 1'b0; exp_sample = '0;
    rd0 = rd_pulses;
    for (int c = 0; c < 1500; c++) begin
      if (prev_tick) begin
        n_checks = n_checks + 2;
        if (sample_valid !== 1'b1) begin n_fail++; $display("FAIL rnd_valid@%0d: got %b expected 1", c, sample_valid); end
        if (sample_out !== exp_sample) begin n_fail++; $display("FAIL rnd_sample@%0d: got %h expected %h", c, sample_out, exp_sample); end
      end
      tick = (since >= 8) && ($urandom_range(0, 5) == 0);
      if (c < 700) wr = !prev_wr && ($urandom_range(0, 11) == 0) && (mdl_level < int'(DEPTH));
      else         wr = !prev_wr && ($urandom_range(0, 2) == 0) && (mdl_level < int'(DEPTH));
      if (tick) begin
        n_checks++;
        if (level !== LVL_W'(mdl_level)) begin n_fail++; $display("FAIL rnd_level@%0d: got %0d expected %0d", c, level, mdl_level); end
        if (mdl_level > 0) begin
          exp_sample = mem[pops % 1024];
          pops       = pops + 1;
          mdl_level  = mdl_level - 1;
        end else begin
          exp_sample = '0;
          exp_ur     = 1'b1;
        end
        since = 0;
      end else begin
        since = since + 1;
      end
      if (wr) begin
        mem[wr_ptr % 1024] = WIDTH'($urandom);
        wr_ptr    = wr_ptr + 1;
        mdl_level = mdl_level + 1;
      end
      sample_tick = tick;
      wr_event    = wr;
      prev_wr     = wr;
      prev_tick   = tick;
      @(negedge clk);
    end
    sample_tick = 1'b0;
    wr_event    = 1'b0;
    repeat (10) @(negedge clk);
    n_checks = n_checks + 4;
    if (level !== LVL_W'(mdl_level)) begin n_fail++; $display("FAIL rnd_final_level: got %0d expected %0d", level, mdl_level); end
    if (underrun !== exp_ur) begin n_fail++; $display("FAIL rnd_underrun: got %b expected %b", underrun, exp_ur); end
    if (rd_pulses - rd0 !== pops) begin n_fail++; $display("FAIL rnd_rd_count: got %0d expected %0d", rd_pulses - rd0, pops); end
    if (dbl_valid !== 0) begin n_fail++; $display("FAIL valid_back_to_back: got %0d expected 0", dbl_valid); end
  endtask

  initial begin
    test_reset();
    test_playback();
    test_underrun();
    test_pending();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_playback_reader.md
Name: fifo_playback_reader

Overview:
- Consumer end of the sample FIFO: drains one sample per audio sample tick and hands it to the playback path (DAC/PWM stage).
- Drives the FIFO's rising-edge-sensitive read strobe with the required low gaps, and honours the FIFO's 2-cycle read latency.
- Tracks FIFO occupancy from the writer's write events and plays silence on underrun.

Parameters:
- WIDTH, 16, sample width in bits; must match the FIFO WIDTH.
- DEPTH, 512, FIFO depth in entries; must match the FIFO DEPTH.
- RD_LATENCY, 2, clock cycles from FIFO read-pointer change to valid FIFO dout.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst_n  in  1  reset, asynchronous assert, active-low. One clock domain only.
- sample_tick  in  1  single-cycle strobe at the audio sample rate.
- wr_event  in  1  single-cycle pulse, one per sample actually written into the FIFO (writer's rising-edge write).
- fifo_rd  out  1  FIFO read strobe. Registered. High for exactly one cycle per advance.
- fifo_dout  in  WIDTH  FIFO head data.
- sample_out  out  WIDTH  current playback sample. Held between ticks.
- sample_valid  out  1  single-cycle pulse when sample_out updates.
- level  out  $clog2(DEPTH+1)  tracked FIFO occupancy.
- underrun  out  1  sticky: a tick found level==0.
- overflow  out  1  sticky: wr_event arrived with level==DEPTH.
- tick_missed  out  1  sticky: a tick arrived while one was already pending.
- clear_flags  in  1  synchronous pulse; clears underrun, overflow and tick_missed.

Behaviour:
- Reset (rst_n low, asynchronous):
  - FSM goes to IDLE.
  - fifo_rd, sample_out, sample_valid, level, all sticky flags and the pending flag go to 0.
  - Reset asserted mid-operation aborts any advance; no further fifo_rd is issued.
- States: IDLE, ADVANCE, SETTLE.
- IDLE with a tick (sample_tick or pending) at cycle t:
  - If level>0: sample_out<=fifo_dout and sample_valid=1, both visible at t+1; go to ADVANCE.
  - If level==0: sample_out<=0 and sample_valid=1 at t+1; set underrun; stay in IDLE; no fifo_rd.
- ADVANCE (cycle t+1):
  - fifo_rd=1.
  - level decrements, visible at t+2.
  - Load settle counter with RD_LATENCY+1; go to SETTLE.
- SETTLE:
  - fifo_rd=0; counter decrements each cycle.
  - Exit to IDLE when the counter reaches 0. With defaults: SETTLE covers t+2..t+4, IDLE at t+5.
  - This guarantees a fifo_rd low gap of at least RD_LATENCY+1 cycles, so the FIFO edge detector and the new head data are settled before the next capture.
- Tick while not in IDLE: set pending. Pending is served on the first IDLE cycle.
- Tick while pending is already set: set tick_missed; the extra tick is dropped.
- Level arithmetic:
  - +1 on wr_event; -1 in the ADVANCE cycle.
  - Both in the same cycle: level unchanged.
  - wr_event at level==DEPTH: level saturates at DEPTH; set overflow (the writer has overwritten unread data).
  - Decrement below 0 is impossible, because ADVANCE is only entered with level>0.
- Sticky flags:
  - clear_flags clears all three flags.
  - If a set event and clear_flags occur in the same cycle, set wins.
- sample_valid is never high for 2 consecutive cycles.

Decomposition:
- daw_pkg holds:
  - sample_t (logic [WIDTH-1:0] at WIDTH=16).
  - the reader_state_t enum {IDLE, ADVANCE, SETTLE}.
  - the SILENCE constant '0.
- One sub-module, fifo_level_tracker: the saturating up/down occupancy counter plus the overflow flag. Inputs are inc, dec and clear; outputs are level and overflow.
- The FSM, pending logic and sample register stay in fifo_playback_reader.

Test Plan:
- Reset, then 3 wr_event pulses with FIFO holding 0x1111, 0x2222, 0x3333; ticks 100 cycles apart -> sample_out = 0x1111, 0x2222, 0x3333; one fifo_rd pulse per tick, at t+1; level 3→2→1→0.
- level=0, tick -> sample_out=0x0000, sample_valid pulse, underrun=1, no fifo_rd; then clear_flags -> underrun=0.
- level=2, ticks at t and t+2 -> second tick pends and is served at t+5; fifo_rd high at t+1 and t+6, low in between; ticks at t, t+1, t+2 -> tick_missed=1.
- 512 wr_events then 1 more -> level stays 512, overflow=1; wr_event and ADVANCE in the same cycle at level=5 -> level stays 5.
- rst_n dropped during ADVANCE -> fifo_rd=0 immediately (asynchronously); state IDLE, level=0, sample_out=0 after release; the next tick with level=0 produces silence.
